stim_pkt_scheduler: RTL

Hardware-side scheduler for the shared stimulus element queue. Several stimulus requesters offer 16-bit elements; the block grants them round-robin into one internal FIFO, then drains the FIFO into 512-bit packets of 32 elements for the result checker. It sits between the stimulus generators and the packet checking path, and replaces ad-hoc per-requester enqueue calls with one arbitrated, back-pressured datapath.

---
 rtl/stim_pkt_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stim_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stim_pkt_scheduler
// Brief    : Round-robin arbiter over NUM_REQ element requesters feeding a
//            circular FIFO, drained by a packer into PKT_ELEMS-element packets.
// Revision : 1.0 - initial release
// ============================================================================
module stim_pkt_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 16,
  parameter int ELEM_W    = 16,
  parameter int PKT_ELEMS = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ELEM_W-1:0]     req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_i,
  output logic                          pkt_valid_o,
  output logic [ELEM_W*PKT_ELEMS-1:0]   pkt_data_o,
  output logic [$clog2(PKT_ELEMS):0]    pkt_count_o,
  input  logic                          pkt_ready_i,
  output logic [$clog2(DEPTH):0]        fifo_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PKT_ELEMS) + 1;

  localparam logic [RR_W:0]    C_NREQ     = (RR_W+1)'(NUM_REQ);
  localparam logic [RR_W-1:0]  C_LAST_REQ = RR_W'(NUM_REQ - 1);
  localparam logic [LVL_W-1:0] C_DEPTH    = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_PKT      = CNT_W'(PKT_ELEMS);

  typedef enum logic [0:0] {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [RR_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]      wr_q, rd_q;
  logic [LVL_W-1:0]      level_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ELEM_W-1:0]     mem_q  [DEPTH];
  logic [ELEM_W-1:0]     slot_q [PKT_ELEMS];

  logic                  full, empty, push, pop, clr;
  logic                  found;
  logic [NUM_REQ-1:0]    grant;
  logic [RR_W-1:0]       gidx, idx;
  logic [RR_W:0]         sum;
  logic [ELEM_W-1:0]     push_data;

  assign full  = (level_q == C_DEPTH);
  assign empty = (level_q == '0);

  // Round-robin search from rr_q upward with wrap; blocked while full.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, rr_q} + (RR_W+1)'(off);
      if (sum >= C_NREQ) sum = sum - C_NREQ;
      idx = sum[RR_W-1:0];
      if (!found && !full && req_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  // Select the granted requester's element for the FIFO write port.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) push_data = req_data_i[i*ELEM_W +: ELEM_W];
    end
  end

  // Grant is forced low while reset is asserted so no handshake is seen.
  assign req_ready_o = grant & {NUM_REQ{rst_n}};
  assign push        = found;
  assign pop         = (state_q == S_FILL) && !empty;
  assign rr_d        = found ? ((gidx == C_LAST_REQ) ? '0 : gidx + 1'b1) : rr_q;

  // Arbiter pointer, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  // Packer next state: fill slots, hold a complete or flushed packet.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      S_FILL: begin
        if (pop) cnt_d = cnt_q + 1'b1;
        if (cnt_d == C_PKT) state_d = S_HOLD;
        else if (flush_i && (cnt_q != '0)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (pkt_ready_i) begin
          state_d = S_FILL;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Packer state, element count and packet slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      for (int k = 0; k < PKT_ELEMS; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < PKT_ELEMS; k++) begin
        if (clr) slot_q[k] <= '0;
        else if (pop && (cnt_q == CNT_W'(k))) slot_q[k] <= mem_q[rd_q];
      end
    end
  end

  generate
    for (genvar k = 0; k < PKT_ELEMS; k++) begin : g_pack
      assign pkt_data_o[k*ELEM_W +: ELEM_W] = slot_q[k];
    end
  endgenerate

  assign pkt_valid_o  = (state_q == S_HOLD);
  assign pkt_count_o  = pkt_valid_o ? cnt_q : '0;
  assign fifo_level_o = level_q;

endmodule
`default_nettype wire
